// File: rtl/pingpong_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler, its job issuer, the DMA loader and the memory subsystem.
// The scheduler itself connects through the master modport.
interface pingpong_tile_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  num_tiles;
    logic [CNT_W-1:0]  k_tiles;
    logic [ADDR_W-1:0] tile_len;
    logic [ADDR_W-1:0] wgt_base;
    logic              load_req;
    logic              load_buf;
    logic              load_ack;
    logic              load_done;
    logic              agu_valid;
    logic [ADDR_W-1:0] agu_addr_A;
    logic [ADDR_W-1:0] agu_addr_B;
    logic              ping_pong_sel;
    logic              accum_mode;
    logic              clear_psum;
    logic              wb_req;
    logic              wb_done;
    logic              busy;
    logic              done;

    modport master (
        input  start, num_tiles, k_tiles, tile_len, wgt_base,
        input  load_ack, load_done, wb_done,
        output load_req, load_buf, agu_valid, agu_addr_A, agu_addr_B,
        output ping_pong_sel, accum_mode, clear_psum, wb_req, busy, done
    );

    modport slave (
        output start, num_tiles, k_tiles, tile_len, wgt_base,
        output load_ack, load_done, wb_done,
        input  load_req, load_buf, agu_valid, agu_addr_A, agu_addr_B,
        input  ping_pong_sel, accum_mode, clear_psum, wb_req, busy, done
    );
endinterface

// File: rtl/pingpong_tile_scheduler.sv
// Ping-pong tile scheduler: a loader fills ActBufA/ActBufB alternately while the compute FSM
// streams the previously filled buffer to the systolic array and manages PSumBuf writeback.
module pingpong_tile_scheduler #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    pingpong_tile_scheduler_if.master bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CLEAR    = 3'd1;
    localparam logic [2:0] S_WAIT_BUF = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_FLUSH    = 3'd4;
    localparam logic [2:0] S_WB       = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_reg, state_next;
    logic [CNT_W-1:0]  num_reg, k_reg;
    logic [ADDR_W-1:0] len_reg, base_reg;
    logic [CNT_W-1:0]  comp_idx_reg, grp_pos_reg, load_idx_reg;
    logic [ADDR_W-1:0] beat_reg, addr_b_reg;
    logic [1:0]        full_reg, full_next;
    logic              outstanding_reg;

    logic cur_buf, last_tile, group_end, last_beat, stream_end, tile_phase;
    logic loader_active, load_tgt, load_req, fill_accept, fill_complete;

    assign cur_buf    = comp_idx_reg[0];
    assign last_tile  = (comp_idx_reg == num_reg - CNT_ONE);
    assign group_end  = (grp_pos_reg == k_reg - CNT_ONE);
    assign last_beat  = (beat_reg == len_reg - ADDR_ONE);
    assign stream_end = (state_reg == S_STREAM) && last_beat;
    assign tile_phase = (state_reg == S_WAIT_BUF) || (state_reg == S_STREAM) || (state_reg == S_FLUSH);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (bus.start) state_next = S_CLEAR;
            S_CLEAR:    state_next = ((num_reg == '0) || (len_reg == '0)) ? S_DONE : S_WAIT_BUF;
            S_WAIT_BUF: if (full_reg[cur_buf]) state_next = S_STREAM;
            S_STREAM:   if (last_beat) state_next = S_FLUSH;
            S_FLUSH:    state_next = (group_end || last_tile) ? S_WB : S_WAIT_BUF;
            S_WB:       if (bus.wb_done) state_next = last_tile ? S_DONE : S_WAIT_BUF;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // grp_pos tracks comp_idx mod k without a divider; addr_b restarts at wgt_base per group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            num_reg      <= '0;
            k_reg        <= '0;
            len_reg      <= '0;
            base_reg     <= '0;
            comp_idx_reg <= '0;
            grp_pos_reg  <= '0;
            beat_reg     <= '0;
            addr_b_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        num_reg  <= bus.num_tiles;
                        k_reg    <= (bus.k_tiles == '0) ? CNT_ONE : bus.k_tiles;
                        len_reg  <= bus.tile_len;
                        base_reg <= bus.wgt_base;
                    end
                end
                S_CLEAR: begin
                    comp_idx_reg <= '0;
                    grp_pos_reg  <= '0;
                    beat_reg     <= '0;
                    addr_b_reg   <= base_reg;
                end
                S_STREAM: begin
                    beat_reg   <= last_beat ? '0 : beat_reg + ADDR_ONE;
                    addr_b_reg <= addr_b_reg + ADDR_ONE;
                end
                S_FLUSH: begin
                    if (!(group_end || last_tile)) begin
                        comp_idx_reg <= comp_idx_reg + CNT_ONE;
                        grp_pos_reg  <= grp_pos_reg + CNT_ONE;
                    end
                end
                S_WB: begin
                    if (bus.wb_done && !last_tile) begin
                        comp_idx_reg <= comp_idx_reg + CNT_ONE;
                        grp_pos_reg  <= '0;
                        addr_b_reg   <= base_reg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign loader_active = (state_reg == S_WAIT_BUF) || (state_reg == S_STREAM) ||
                           (state_reg == S_FLUSH) || (state_reg == S_WB);
    assign load_tgt      = load_idx_reg[0];
    assign load_req      = loader_active && (load_idx_reg < num_reg) &&
                           !full_reg[load_tgt] && !outstanding_reg;
    assign fill_accept   = load_req && bus.load_ack;
    // A done pulse only counts against an accepted fill, possibly accepted this very cycle.
    assign fill_complete = bus.load_done && (outstanding_reg || fill_accept);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_idx_reg    <= '0;
            outstanding_reg <= 1'b0;
        end else if (state_reg == S_CLEAR) begin
            load_idx_reg    <= '0;
            outstanding_reg <= 1'b0;
        end else if (fill_complete) begin
            load_idx_reg    <= load_idx_reg + CNT_ONE;
            outstanding_reg <= 1'b0;
        end else if (fill_accept) begin
            outstanding_reg <= 1'b1;
        end
    end

    // The buffer being streamed stays full until its last beat, so the loader cannot target it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = (state_reg == S_CLEAR)                 ? 1'b0 :
                                   (fill_complete && load_tgt == 1'(gi))  ? 1'b1 :
                                   (stream_end && cur_buf == 1'(gi))      ? 1'b0 :
                                                                            full_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full_reg <= 2'b00;
        else        full_reg <= full_next;
    end

    assign bus.load_req      = load_req;
    assign bus.load_buf      = load_req & load_tgt;
    assign bus.agu_valid     = (state_reg == S_STREAM);
    assign bus.agu_addr_A    = (state_reg == S_STREAM) ? beat_reg : '0;
    assign bus.agu_addr_B    = (state_reg == S_STREAM) ? addr_b_reg : '0;
    assign bus.ping_pong_sel = tile_phase & cur_buf;
    assign bus.accum_mode    = tile_phase & (grp_pos_reg != '0);
    assign bus.clear_psum    = (state_reg == S_CLEAR);
    assign bus.wb_req        = (state_reg == S_WB);
    assign bus.busy          = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign bus.done          = (state_reg == S_DONE);
endmodule

// File: tb/tb_pingpong_tile_scheduler.sv
// Directed and randomized jobs against a tile-level reference model; DMA and writeback
// responders run in one negedge process that also records every beat, fill and writeback.
module tb_pingpong_tile_scheduler;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pingpong_tile_scheduler_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pingpong_tile_scheduler #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [33:0] beats_q[$];
    logic        loads_q[$];
    int          wb_q[$];
    int clear_cnt, done_cnt, clear_cyc, done_cyc, fills_done;
    int cfg_len = 1;
    int dmode = 0;
    bit spurious = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_vec();
        return {23'd0, bus.load_req, bus.load_buf, bus.agu_valid, bus.agu_addr_A, bus.agu_addr_B,
                bus.ping_pong_sel, bus.accum_mode, bus.clear_psum, bus.wb_req, bus.busy, bus.done};
    endfunction

    // Environment: monitor first, then drive DMA/writeback responses for the next edge.
    initial begin
        bit fill_pending;
        bit wb_pending;
        int fill_wait;
        int wb_wait;
        int d;
        int m;
        fill_pending = 1'b0;
        wb_pending   = 1'b0;
        fill_wait    = 0;
        wb_wait      = 0;
        bus.load_ack  = 1'b0;
        bus.load_done = 1'b0;
        bus.wb_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.load_ack  = 1'b0;
                bus.load_done = 1'b0;
                bus.wb_done   = 1'b0;
                fill_pending  = 1'b0;
                wb_pending    = 1'b0;
            end else begin
                if (bus.agu_valid) begin
                    if (bus.agu_addr_A == '0 && cfg_len > 0)
                        chk("stream_needs_fill", 64'((beats_q.size() / cfg_len) < fills_done), 64'd1);
                    beats_q.push_back({bus.agu_addr_A, bus.agu_addr_B, bus.ping_pong_sel, bus.accum_mode});
                end
                if (bus.clear_psum) begin clear_cnt++; clear_cyc = cyc; end
                if (bus.done) begin done_cnt++; done_cyc = cyc; end

                bus.load_ack  = 1'b0;
                bus.load_done = 1'b0;
                if (fill_pending) begin
                    if (fill_wait == 0) begin
                        bus.load_done = 1'b1;
                        fill_pending  = 1'b0;
                        fills_done++;
                    end else fill_wait--;
                end else if (bus.load_req) begin
                    m = loads_q.size();
                    if (m >= 2)
                        chk("load_ahead", 64'(beats_q.size() >= (m - 1) * cfg_len), 64'd1);
                    loads_q.push_back(bus.load_buf);
                    bus.load_ack = 1'b1;
                    d = (dmode == 2) ? 20 : (dmode == 1) ? int'($urandom_range(0, 3)) : 0;
                    if (d == 0) begin
                        bus.load_done = 1'b1;
                        fills_done++;
                    end else begin
                        fill_pending = 1'b1;
                        fill_wait    = d - 1;
                    end
                end else if (spurious && $urandom_range(0, 3) == 0) begin
                    bus.load_done = 1'b1;
                end

                bus.wb_done = 1'b0;
                if (wb_pending) begin
                    if (wb_wait == 0) begin
                        bus.wb_done = 1'b1;
                        wb_pending  = 1'b0;
                    end else wb_wait--;
                end else if (bus.wb_req) begin
                    wb_q.push_back(beats_q.size());
                    wb_wait = int'($urandom_range(0, 2));
                    if (wb_wait == 0) bus.wb_done = 1'b1;
                    else begin
                        wb_pending = 1'b1;
                        wb_wait--;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        beats_q.delete();
        loads_q.delete();
        wb_q.delete();
        clear_cnt  = 0;
        done_cnt   = 0;
        fills_done = 0;
    endtask

    task automatic run_job(input int num, input int k, input int len, input int base,
                           input int mode, input bit poke);
        int kk;
        int start_cyc;
        bit finished;
        logic [33:0] exp_beats[$];
        logic        exp_loads[$];
        int          exp_wb[$];
        logic [15:0] ea, eb;
        int n_cmp;

        clear_logs();
        cfg_len = len;
        dmode   = mode;
        @(negedge clk);
        bus.num_tiles = CNT_W'(num);
        bus.k_tiles   = CNT_W'(k);
        bus.tile_len  = ADDR_W'(len);
        bus.wgt_base  = ADDR_W'(base);
        bus.start     = 1'b1;
        start_cyc     = cyc;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.num_tiles = CNT_W'($urandom);
        bus.k_tiles   = CNT_W'($urandom);
        bus.tile_len  = ADDR_W'($urandom);
        bus.wgt_base  = ADDR_W'($urandom);
        finished = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (bus.done) begin
                finished = 1'b1;
                break;
            end
            bus.start = poke && (c == 6) && bus.busy;
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (2) @(negedge clk);

        // Reference model: tile n, beat j reads word j and weight base + (n mod k)*len + j.
        kk = (k == 0) ? 1 : k;
        if (num > 0 && len > 0) begin
            for (int n = 0; n < num; n++) begin
                exp_loads.push_back((n % 2) == 1);
                for (int j = 0; j < len; j++) begin
                    ea = 16'(j);
                    eb = 16'(base + (n % kk) * len + j);
                    exp_beats.push_back({ea, eb, (n % 2) == 1, (n % kk) != 0});
                end
                if (((n + 1) % kk) == 0 || n == num - 1) exp_wb.push_back((n + 1) * len);
            end
        end

        chk("job_finished", 64'(finished), 64'd1);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("clear_pulses", 64'(clear_cnt), 64'd1);
        chk("clear_cycle", 64'(clear_cyc), 64'(start_cyc + 1));
        if (num == 0 || len == 0) chk("degenerate_done_cycle", 64'(done_cyc), 64'(start_cyc + 2));
        chk("beat_count", 64'(beats_q.size()), 64'(exp_beats.size()));
        n_cmp = (beats_q.size() < exp_beats.size()) ? beats_q.size() : exp_beats.size();
        for (int i = 0; i < n_cmp; i++)
            chk($sformatf("beat%0d", i), 64'(beats_q[i]), 64'(exp_beats[i]));
        chk("load_count", 64'(loads_q.size()), 64'(exp_loads.size()));
        n_cmp = (loads_q.size() < exp_loads.size()) ? loads_q.size() : exp_loads.size();
        for (int i = 0; i < n_cmp; i++)
            chk($sformatf("load_buf%0d", i), 64'(loads_q[i]), 64'(exp_loads[i]));
        chk("wb_count", 64'(wb_q.size()), 64'(exp_wb.size()));
        n_cmp = (wb_q.size() < exp_wb.size()) ? wb_q.size() : exp_wb.size();
        for (int i = 0; i < n_cmp; i++)
            chk($sformatf("wb_after_beats%0d", i), 64'(wb_q[i]), 64'(exp_wb[i]));
        chk("busy_after", 64'(bus.busy), 64'd0);
        $display("[TB] job num=%0d k=%0d len=%0d base=0x%0h mode=%0d: %0d beats, %0d loads, %0d wb",
                 num, k, len, base, mode, beats_q.size(), loads_q.size(), wb_q.size());
    endtask

    initial begin
        bit reached;
        bus.start     = 1'b0;
        bus.num_tiles = '0;
        bus.k_tiles   = '0;
        bus.tile_len  = '0;
        bus.wgt_base  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", out_vec(), 64'd0);

        run_job(4, 4, 8, 'h0000, 0, 1'b0);
        run_job(4, 2, 3, 'h0100, 0, 1'b0);
        run_job(5, 3, 4, 'h2000, 2, 1'b0);
        run_job(0, 2, 5, 'h0010, 0, 1'b0);
        run_job(3, 1, 0, 'h0010, 0, 1'b0);
        spurious = 1'b1;
        run_job(6, 2, 5, 'hFFFC, 1, 1'b1);
        spurious = 1'b0;

        // Abandon a job in the middle of tile 2 with an asynchronous reset.
        clear_logs();
        cfg_len = 6;
        dmode   = 0;
        @(negedge clk);
        bus.num_tiles = 16'd5;
        bus.k_tiles   = 16'd2;
        bus.tile_len  = 16'd6;
        bus.wgt_base  = 16'h0300;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (beats_q.size() >= 15) begin
                reached = 1'b1;
                break;
            end
        end
        chk("reached_tile2", 64'(reached), 64'd1);
        chk("pre_reset_stream", 64'(bus.agu_valid), 64'd1);
        chk("pre_reset_sel", 64'(bus.ping_pong_sel), 64'd0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", out_vec(), 64'd0);
        $display("[TB] reset asserted mid-stream after %0d beats", beats_q.size());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_job(5, 0, 3, 'h0040, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            spurious = 1'($urandom_range(0, 1));
            run_job(int'($urandom_range(1, 7)), int'($urandom_range(0, 4)), int'($urandom_range(1, 6)),
                    (r % 3 == 0) ? int'($urandom_range(16'hFFF0, 16'hFFFF)) : int'($urandom_range(0, 16'hFFFF)),
                    1, 1'($urandom_range(0, 1)));
        end
        spurious = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pingpong_tile_scheduler.md
Name: pingpong_tile_scheduler

Overview:
- Sequences tiled convolution/GEMM passes through the banked activation, weight and partial-sum memory subsystem.
- A loader engine asks the DMA to fill ActBufA/ActBufB alternately. A compute engine streams each filled buffer to the systolic array by driving agu_valid/agu_addr_A/agu_addr_B/ping_pong_sel.
- Computation of tile n overlaps the DMA fill of tile n+1.
- Also drives accum_mode, clear_psum and the per-output-group PSumBuf writeback handshake.

Parameters:
ADDR_W, 16, width of agu_addr_A/agu_addr_B and tile_len
CNT_W, 16, width of tile counters (num_tiles, k_tiles)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  pulse; begins a job, sampled only in IDLE
num_tiles  in  CNT_W  total tiles in job, latched at start
k_tiles  in  CNT_W  tiles per accumulation group (C_in split), latched; 0 treated as 1
tile_len  in  ADDR_W  AGU beats per tile, latched
wgt_base  in  ADDR_W  weight start address, latched
load_req  out  1  DMA fill request, held until load_ack
load_buf  out  1  target buffer for the fill (0=ActBufA, 1=ActBufB)
load_ack  in  1  DMA accepted request
load_done  in  1  pulse; outstanding fill complete
agu_valid  out  1  read beat to memory subsystem
agu_addr_A  out  ADDR_W  activation word address (0..tile_len-1)
agu_addr_B  out  ADDR_W  weight address = wgt_base + running beat count (wraps mod 2^ADDR_W)
ping_pong_sel  out  1  buffer being computed
accum_mode  out  1  0 on first tile of a group, 1 otherwise
clear_psum  out  1  one-cycle pulse at job start
wb_req  out  1  PSumBuf writeback request, held until wb_done
wb_done  in  1  pulse; writeback complete
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: all outputs 0. Both buffer full flags cleared. Counters cleared. Both FSMs go to IDLE; an in-flight job is abandoned.
- Main FSM states: IDLE, CLEAR, WAIT_BUF, STREAM, FLUSH, WB, DONE.
- IDLE→CLEAR on start: latch inputs, busy=1, clear_psum=1 for exactly the CLEAR cycle.
- start while busy is ignored.
- If num_tiles==0 or tile_len==0: CLEAR→DONE, no loads issued, no agu_valid asserted.
- CLEAR→WAIT_BUF.
- WAIT_BUF: buffer b=comp_idx[0]. Move to STREAM when full[b]. ping_pong_sel=b in the same cycle and through STREAM.
- STREAM: agu_valid=1 for exactly tile_len consecutive cycles; agu_addr_A counts 0..tile_len-1.
- accum_mode=(comp_idx mod k_tiles)!=0, constant for the whole tile.
- On the last beat, full[b] is cleared; go to FLUSH.
- FLUSH: one cycle, covers the 1-cycle read latency to data_valid.
- After FLUSH:
  - group end ((comp_idx+1) mod k_tiles==0) or last tile → WB.
  - otherwise comp_idx++ → WAIT_BUF.
- WB: wb_req=1 until the cycle wb_done is seen.
  - If last tile → DONE; else comp_idx++, beat counter reset to wgt_base, → WAIT_BUF.
- DONE: done=1 one cycle, busy=0, → IDLE.
- Loader (runs concurrently while busy, after CLEAR):
  - Target t=load_idx[0]. If load_idx<num_tiles, !full[t], and no fill outstanding: assert load_req with load_buf=t.
  - On load_ack: drop load_req, mark outstanding.
  - On load_done: full[t]=1, load_idx++, clear outstanding.
  - load_done with no outstanding fill is ignored.
  - load_ack and load_done may arrive in the same cycle as the request; the fill completes immediately.
- Buffer that is being streamed stays full until its last beat, so it is never refilled mid-read.
- If load_done sets full[b] in the cycle WAIT_BUF samples b, STREAM starts the next cycle; no bypass.
- At most 2 tiles are resident; load_idx ≤ comp_idx+2 always holds.
- Counter widths: comp_idx, load_idx CNT_W; modulo uses the latched k_tiles (≥1).

Test Plan:
- num_tiles=4, k_tiles=4, tile_len=8, immediate load_ack/load_done → load_buf sequence 0,1,0,1; 32 agu_valid beats; accum_mode 0 on tile0 only; one wb_req; done once; clear_psum one cycle after start.
- num_tiles=4, k_tiles=2, tile_len=3, wgt_base=0x100 → wb_req after tiles 1 and 3; accum_mode pattern 0,1,0,1; agu_addr_B 0x100..0x105 per group.
- Slow DMA (load_done 20 cycles after ack), tile_len=4 → gaps in WAIT_BUF, no agu_valid without full buffer, ping_pong_sel toggles per tile.
- num_tiles=0 or tile_len=0 → done 2 cycles after start, no load_req, no agu_valid.
- rst_n low mid-STREAM on tile 2 → all outputs 0 asynchronously; a new start runs a full job correctly.
- start pulsed while busy, and load_done with nothing outstanding → both ignored; beat/tile counts unchanged.
